input_decoder: RTL and testbench

// - Receive-side counterpart of the HDLC line encoder. Takes the 8-bit oversampled

---
 rtl/input_decoder.sv | 224 ++++++++++++++++++++++
 tb/tb_input_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_decoder.sv
`default_nettype none
// ============================================================================
// Module      : input_decoder
// Description : Receive-side symbol decoder for the HDLC line encoder. Word-
//               aligns the 8-bit oversampled deserializer stream with a
//               bit-slip search, decodes 8'h96 -> 0 and 8'h99 -> 1, and
//               passes any other aligned word through as a bus word.
// Optional    : `define DEC_ERR_CNT_EN enables the 16-bit saturating
//               code-violation counter on err_count.
// Ports       : clk        - clock, all logic on posedge
//               rst        - synchronous active-high reset
//               din[7:0]   - raw deserialized word, one per clk
//               err_clr    - synchronous clear of err_count
//               data_out   - decoded bit, qualified by data_valid
//               data_valid - data_out carries a decoded symbol
//               bus_out    - aligned word (updates every locked cycle)
//               bus_valid  - locked and aligned word is not a symbol
//               code_err   - aligned word is one bit away from a symbol
//               locked     - alignment state is LOCKED
//               offset     - current bit-slip offset
//               err_count  - code-violation count
// Revision    : 1.0 - initial release
// ============================================================================
module input_decoder #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        err_clr,
  output logic        data_out,
  output logic        data_valid,
  output logic [7:0]  bus_out,
  output logic        bus_valid,
  output logic        code_err,
  output logic        locked,
  output logic [2:0]  offset,
  output logic [15:0] err_count
);

  localparam logic [7:0] c_sym0 = 8'h96;
  localparam logic [7:0] c_sym1 = 8'h99;

  // Counters only ever hold values up to (threshold - 1); reaching the
  // threshold is detected combinationally and causes the state change.
  localparam int LW = (LOCK_CNT   > 1) ? $clog2(LOCK_CNT)   : 1;
  localparam int MW = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT) : 1;
  localparam logic [LW-1:0] c_hlast = LW'(LOCK_CNT - 1);
  localparam logic [MW-1:0] c_mlast = MW'(UNLOCK_CNT - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        r_state, w_state_n;
  logic [7:0]    r_d1;
  logic [2:0]    r_offset, w_offset_n;
  logic [LW-1:0] r_hcnt, w_hcnt_n;
  logic [MW-1:0] r_mcnt, w_mcnt_n;
  logic          r_data_out, w_data_out_n;
  logic          r_data_valid, w_data_valid_n;
  logic [7:0]    r_bus_out, w_bus_out_n;
  logic          r_bus_valid, w_bus_valid_n;
  logic          r_code_err, w_code_err_n;

  logic [15:0]   w_win;
  logic [7:0]    w_word [8];
  logic [7:0]    w_sym;
  logic          w_any;
  logic [2:0]    w_first;
  logic [7:0]    w_a;
  logic          w_a_sym;
  logic          w_a_near;

  function automatic logic one_bit(input logic [7:0] x);
    return (x != 8'h00) && ((x & (x - 8'h01)) == 8'h00);
  endfunction

  // Alignment window: previous word followed by the current one.
  always_comb begin
    w_win = {r_d1, din};
    for (int k = 0; k < 8; k++) begin
      w_word[k] = w_win[15-k -: 8];
      w_sym[k]  = (w_word[k] == c_sym0) || (w_word[k] == c_sym1);
    end
  end

  // Lowest offset holding a valid symbol; scanning downward leaves the
  // smallest match as the final assignment.
  always_comb begin
    w_any   = 1'b0;
    w_first = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_sym[k]) begin
        w_any   = 1'b1;
        w_first = 3'(k);
      end
    end
  end

  always_comb begin
    w_a      = w_word[r_offset];
    w_a_sym  = w_sym[r_offset];
    w_a_near = one_bit(w_a ^ c_sym0) || one_bit(w_a ^ c_sym1);
  end

  always_comb begin
    w_state_n      = r_state;
    w_offset_n     = r_offset;
    w_hcnt_n       = r_hcnt;
    w_mcnt_n       = r_mcnt;
    w_data_out_n   = 1'b0;
    w_data_valid_n = 1'b0;
    w_bus_out_n    = r_bus_out;
    w_bus_valid_n  = 1'b0;
    w_code_err_n   = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_a_sym) begin
          if (r_hcnt >= c_hlast) begin
            w_state_n = LOCKED;
            w_hcnt_n  = '0;
            w_mcnt_n  = '0;
          end else begin
            w_hcnt_n = r_hcnt + 1'b1;
          end
        end else if (w_any) begin
          // Slip to the new candidate; the match found counts as the first.
          w_offset_n = w_first;
          if (LOCK_CNT <= 1) begin
            w_state_n = LOCKED;
            w_hcnt_n  = '0;
            w_mcnt_n  = '0;
          end else begin
            w_hcnt_n = LW'(1);
          end
        end else begin
          w_hcnt_n = '0;
        end
      end
      LOCKED: begin
        w_bus_out_n = w_a;
        if (w_a_sym) begin
          w_data_valid_n = 1'b1;
          w_data_out_n   = (w_a == c_sym1);
          w_mcnt_n       = '0;
        end else begin
          w_code_err_n = w_a_near;
          if (r_mcnt >= c_mlast) begin
            // Dropping lock: bus_valid falls together with locked.
            w_state_n = HUNT;
            w_mcnt_n  = '0;
            w_hcnt_n  = '0;
          end else begin
            w_mcnt_n      = r_mcnt + 1'b1;
            w_bus_valid_n = 1'b1;
          end
        end
      end
      default: begin
        w_state_n = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HUNT;
      r_d1         <= 8'h00;
      r_offset     <= 3'd0;
      r_hcnt       <= '0;
      r_mcnt       <= '0;
      r_data_out   <= 1'b0;
      r_data_valid <= 1'b0;
      r_bus_out    <= 8'h00;
      r_bus_valid  <= 1'b0;
      r_code_err   <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_d1         <= din;
      r_offset     <= w_offset_n;
      r_hcnt       <= w_hcnt_n;
      r_mcnt       <= w_mcnt_n;
      r_data_out   <= w_data_out_n;
      r_data_valid <= w_data_valid_n;
      r_bus_out    <= w_bus_out_n;
      r_bus_valid  <= w_bus_valid_n;
      r_code_err   <= w_code_err_n;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign bus_out    = r_bus_out;
  assign bus_valid  = r_bus_valid;
  assign code_err   = r_code_err;
  assign locked     = (r_state == LOCKED);
  assign offset     = r_offset;

`ifdef DEC_ERR_CNT_EN
  logic [15:0] r_err_count;

  // Counts the pulse on the same edge it is registered; clear has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= 16'h0000;
    end else if (err_clr) begin
      r_err_count <= 16'h0000;
    end else if (w_code_err_n && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'h0001;
    end
  end

  assign err_count = r_err_count;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign err_count        = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_decoder
// Description : Directed self-checking bench for input_decoder. Each task
//               drives one scenario and compares outputs against values
//               worked out by hand from the decoding rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        err_clr = 1'b0;
  logic        data_out, data_valid, bus_valid, code_err, locked;
  logic [7:0]  bus_out;
  logic [2:0]  offset;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;

`ifdef DEC_ERR_CNT_EN
  localparam bit c_cnt_en = 1'b1;
`else
  localparam bit c_cnt_en = 1'b0;
`endif

  input_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .err_clr    (err_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .bus_out    (bus_out),
    .bus_valid  (bus_valid),
    .code_err   (code_err),
    .locked     (locked),
    .offset     (offset),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Present one word, let the edge consume it, sample 1 ns later.
  // Outputs seen after cyc(X) describe the word driven on the previous call.
  task automatic cyc(input logic [7:0] v);
    din = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(8'h55);
    cyc(8'h55);
    rst = 1'b0;
    total++;
    if ({data_out, data_valid, bus_out, bus_valid, code_err, locked, offset, err_count} !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got do=%b dv=%b bus=%h bv=%b ce=%b lk=%b off=%0d ec=%h, want all 0",
               data_out, data_valid, bus_out, bus_valid, code_err, locked, offset, err_count);
    end
  endtask

  task automatic test_lock;
    cyc(8'h96); cyc(8'h99); cyc(8'h96); cyc(8'h99);
    total++;
    if (locked !== 1'b0 || data_valid !== 1'b0) begin
      bad++; $display("FAIL lock_early: got locked=%b dv=%b, want 0 0", locked, data_valid);
    end
    cyc(8'h96);
    total++;
    if (locked !== 1'b1 || data_valid !== 1'b0 || offset !== 3'd0) begin
      bad++; $display("FAIL lock_at4: got locked=%b dv=%b off=%0d, want 1 0 0", locked, data_valid, offset);
    end
    cyc(8'h99);
    total++;
    if (data_valid !== 1'b1 || data_out !== 1'b0) begin
      bad++; $display("FAIL lock_bit0: got dv=%b do=%b, want 1 0", data_valid, data_out);
    end
    cyc(8'h96);
    total++;
    if (data_valid !== 1'b1 || data_out !== 1'b1) begin
      bad++; $display("FAIL lock_bit1: got dv=%b do=%b, want 1 1", data_valid, data_out);
    end
  endtask

  task automatic test_bus;
    cyc(8'h3C);
    total++;
    if (data_valid !== 1'b1 || data_out !== 1'b0 || bus_valid !== 1'b0) begin
      bad++; $display("FAIL bus_pre: got dv=%b do=%b bv=%b, want 1 0 0", data_valid, data_out, bus_valid);
    end
    cyc(8'hA5);
    total++;
    if (bus_valid !== 1'b1 || bus_out !== 8'h3C || data_valid !== 1'b0 || code_err !== 1'b0) begin
      bad++; $display("FAIL bus_3c: got bv=%b bus=%h dv=%b ce=%b, want 1 3c 0 0", bus_valid, bus_out, data_valid, code_err);
    end
    cyc(8'h96);
    total++;
    if (bus_valid !== 1'b1 || bus_out !== 8'hA5 || data_valid !== 1'b0 || code_err !== 1'b0) begin
      bad++; $display("FAIL bus_a5: got bv=%b bus=%h dv=%b ce=%b, want 1 a5 0 0", bus_valid, bus_out, data_valid, code_err);
    end
    cyc(8'h99);
    total++;
    if (bus_valid !== 1'b0 || data_valid !== 1'b1 || bus_out !== 8'h96) begin
      bad++; $display("FAIL bus_back_to_sym: got bv=%b dv=%b bus=%h, want 0 1 96", bus_valid, data_valid, bus_out);
    end
  endtask

  task automatic test_code_err;
    cyc(8'h97);
    cyc(8'h96);
    total++;
    if (code_err !== 1'b1 || bus_valid !== 1'b1 || bus_out !== 8'h97) begin
      bad++; $display("FAIL cerr_pulse: got ce=%b bv=%b bus=%h, want 1 1 97", code_err, bus_valid, bus_out);
    end
    total++;
    if (err_count !== (c_cnt_en ? 16'd1 : 16'd0)) begin
      bad++; $display("FAIL cerr_count: got %0d want %0d", err_count, c_cnt_en ? 1 : 0);
    end
    cyc(8'h96);
    total++;
    if (code_err !== 1'b0 || data_valid !== 1'b1) begin
      bad++; $display("FAIL cerr_one_cycle: got ce=%b dv=%b, want 0 1", code_err, data_valid);
    end
    err_clr = 1'b1;
    cyc(8'h97);
    err_clr = 1'b0;
    total++;
    if (err_count !== 16'd0) begin
      bad++; $display("FAIL cerr_clear: got %0d want 0", err_count);
    end
    // Clear arrives on the same edge as a new violation: clear wins.
    cyc(8'h99);
    cyc(8'h96);
    total++;
    if (err_count !== (c_cnt_en ? 16'd1 : 16'd0)) begin
      bad++; $display("FAIL cerr_recount: got %0d want %0d", err_count, c_cnt_en ? 1 : 0);
    end
    cyc(8'h97);
    err_clr = 1'b1;
    cyc(8'h99);
    err_clr = 1'b0;
    total++;
    if (code_err !== 1'b1 || err_count !== 16'd0) begin
      bad++; $display("FAIL cerr_clr_wins: got ce=%b ec=%0d, want 1 0", code_err, err_count);
    end
  endtask

  task automatic test_lock_loss;
    cyc(8'h99);
    for (int z = 1; z <= 17; z++) begin
      cyc(8'h00);
      if (z == 16) begin
        total++;
        if (locked !== 1'b1 || bus_valid !== 1'b1 || bus_out !== 8'h00) begin
          bad++; $display("FAIL loss_15: got locked=%b bv=%b bus=%h, want 1 1 00", locked, bus_valid, bus_out);
        end
      end
    end
    total++;
    if (locked !== 1'b0 || bus_valid !== 1'b0 || offset !== 3'd0) begin
      bad++; $display("FAIL loss_16: got locked=%b bv=%b off=%0d, want 0 0 0", locked, bus_valid, offset);
    end
    cyc(8'h96); cyc(8'h99); cyc(8'h96); cyc(8'h99);
    total++;
    if (locked !== 1'b0 || data_valid !== 1'b0) begin
      bad++; $display("FAIL relock_early: got locked=%b dv=%b, want 0 0", locked, data_valid);
    end
    cyc(8'h96);
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL relock: got locked=%b want 1", locked);
    end
  endtask

  task automatic test_bitslip;
    localparam int NSYM = 12;
    localparam int NB   = NSYM + 1;
    logic       src [NSYM];
    logic       bits [NB*8];
    logic [7:0] sym;
    logic [7:0] b;
    logic       got [$];
    src = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < NB*8; i++) bits[i] = 1'b0;
    // Three leading filler bits put every symbol at bit-slip offset 3.
    for (int i = 0; i < NSYM; i++) begin
      sym = src[i] ? 8'h99 : 8'h96;
      for (int j = 0; j < 8; j++) bits[3 + 8*i + j] = sym[7-j];
    end
    test_reset();
    for (int j = 0; j < NB; j++) begin
      for (int t = 0; t < 8; t++) b[7-t] = bits[8*j + t];
      cyc(b);
      if (data_valid === 1'b1) got.push_back(data_out);
    end
    total++;
    if (offset !== 3'd3 || locked !== 1'b1) begin
      bad++; $display("FAIL slip_offset: got off=%0d locked=%b, want 3 1", offset, locked);
    end
    // First LOCK_CNT symbols are consumed by the hunt.
    total++;
    if (got.size() != NSYM - 4) begin
      bad++; $display("FAIL slip_count: got %0d bits want %0d", got.size(), NSYM - 4);
    end else begin
      for (int i = 0; i < NSYM - 4; i++) begin
        total++;
        if (got[i] !== src[i+4]) begin
          bad++; $display("FAIL slip_bit%0d: got %b want %b", i, got[i], src[i+4]);
        end
      end
    end
  endtask

  task automatic test_midreset;
    rst = 1'b1;
    cyc(8'h96);
    rst = 1'b0;
    total++;
    if ({data_out, data_valid, bus_out, bus_valid, code_err, locked, offset} !== 16'h0) begin
      bad++; $display("FAIL midrst_outputs: got do=%b dv=%b bus=%h bv=%b ce=%b lk=%b off=%0d, want all 0",
                      data_out, data_valid, bus_out, bus_valid, code_err, locked, offset);
    end
    cyc(8'h99);
    total++;
    if (data_valid !== 1'b0 || locked !== 1'b0 || bus_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_no_partial: got dv=%b lk=%b bv=%b, want 0 0 0", data_valid, locked, bus_valid);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_bus();
    test_code_err();
    test_lock_loss();
    test_bitslip();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
